// File: rtl/pipe_ctrl_seq_if.sv
// ID-stage control bus: instruction/hazard inputs toward the control unit and
// the registered ID/EX control word plus stall/flush outputs back out.
interface pipe_ctrl_seq_if #(
    parameter int OP_W   = 4,
    parameter int FUNC_W = 4
);
    logic              in_valid;
    logic [OP_W-1:0]   opcode;
    logic [FUNC_W-1:0] func;
    logic              br_taken;
    logic              ld_use;

    logic              ex_valid;
    logic              ex_offset;
    logic              ex_imm;
    logic              ex_down;
    logic              ex_mbyte;
    logic              ex_mv1src;
    logic              ex_fdst;
    logic [1:0]        ex_bra;
    logic [1:0]        ex_wdst;
    logic [1:0]        ex_memw;
    logic              ex_wb;
    logic              stall;
    logic              if_flush_n;
    logic              id_flush_n;
    logic              muldiv_busy;
    logic              halted;

    // Pipeline side: supplies the ID instruction and hazard info.
    modport master (
        output in_valid, opcode, func, br_taken, ld_use,
        input  ex_valid, ex_offset, ex_imm, ex_down, ex_mbyte, ex_mv1src, ex_fdst,
        input  ex_bra, ex_wdst, ex_memw, ex_wb,
        input  stall, if_flush_n, id_flush_n, muldiv_busy, halted
    );

    // Control unit side.
    modport slave (
        input  in_valid, opcode, func, br_taken, ld_use,
        output ex_valid, ex_offset, ex_imm, ex_down, ex_mbyte, ex_mv1src, ex_fdst,
        output ex_bra, ex_wdst, ex_memw, ex_wb,
        output stall, if_flush_n, id_flush_n, muldiv_busy, halted
    );
endinterface

// File: rtl/pipe_ctrl_seq.sv
// Sequential ID-stage control unit: decodes opcode/func into a registered
// ID/EX control word and sequences MUL/DIV occupancy, load-use stalls,
// taken-branch flushes and HALT.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  S_RUN    | normal issue; decode latched into ID/EX each cycle
//  S_MULDIV | MUL/DIV occupying EX; PC and IF/ID held, ID/EX holds its word
//  S_HALT   | HALT retired into ID/EX; bubbles forever until rst
module pipe_ctrl_seq #(
    parameter int OP_W       = 4,
    parameter int FUNC_W     = 4,
    parameter int MULDIV_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    pipe_ctrl_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(MULDIV_LAT + 1);

    localparam logic [OP_W-1:0] OPC_HALT  = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OPC_BGT   = OP_W'(4'b0100);
    localparam logic [OP_W-1:0] OPC_BLT   = OP_W'(4'b0101);
    localparam logic [OP_W-1:0] OPC_BEQ   = OP_W'(4'b0110);
    localparam logic [OP_W-1:0] OPC_IMM0  = OP_W'(4'b1000);
    localparam logic [OP_W-1:0] OPC_IMM1  = OP_W'(4'b1001);
    localparam logic [OP_W-1:0] OPC_LB    = OP_W'(4'b1010);
    localparam logic [OP_W-1:0] OPC_SB    = OP_W'(4'b1011);
    localparam logic [OP_W-1:0] OPC_LW    = OP_W'(4'b1100);
    localparam logic [OP_W-1:0] OPC_SW    = OP_W'(4'b1101);
    localparam logic [OP_W-1:0] OPC_ATYPE = OP_W'(4'b1111);

    localparam logic [FUNC_W-1:0] FN_MUL  = FUNC_W'(4'b0100);
    localparam logic [FUNC_W-1:0] FN_DIV  = FUNC_W'(4'b0101);
    localparam logic [FUNC_W-1:0] FN_MOVE = FUNC_W'(4'b0111);
    localparam logic [FUNC_W-1:0] FN_SWAP = FUNC_W'(4'b1000);

    typedef enum logic [1:0] {S_RUN, S_MULDIV, S_HALT} state_t;

    typedef struct packed {
        logic       valid;
        logic       offset;
        logic       imm;
        logic       down;
        logic       mbyte;
        logic       mv1src;
        logic       fdst;
        logic [1:0] bra;
        logic [1:0] wdst;
        logic [1:0] memw;
        logic       wb;
    } ctrl_t;

    // Bubble keeps the neutral operand source and "no branch" so EX ignores it.
    localparam ctrl_t BUBBLE = '{valid: 1'b0, offset: 1'b0, imm: 1'b0, down: 1'b0,
                                 mbyte: 1'b0, mv1src: 1'b1, fdst: 1'b0, bra: 2'b11,
                                 wdst: 2'b00, memw: 2'b00, wb: 1'b0};

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    ctrl_t            ex_q;

    ctrl_t dec_d;
    logic  is_halt_d;
    logic  is_muldiv_d;
    logic  take_flush;
    logic  stall;

    // Combinational decode of the instruction currently in ID.
    always_comb begin
        dec_d        = BUBBLE;
        dec_d.valid  = 1'b1;
        dec_d.wb     = 1'b1;
        is_halt_d    = 1'b0;
        is_muldiv_d  = 1'b0;
        case (bus.opcode)
            OPC_ATYPE: begin
                case (bus.func)
                    FN_MUL, FN_DIV: begin
                        dec_d.wdst  = 2'b10;
                        is_muldiv_d = 1'b1;
                    end
                    FN_MOVE: dec_d.mv1src = 1'b0;
                    FN_SWAP: begin
                        dec_d.mv1src = 1'b0;
                        dec_d.wdst   = 2'b01;
                    end
                    default: ;
                endcase
            end
            OPC_IMM0, OPC_IMM1: dec_d.imm = 1'b1;
            OPC_LB: begin
                dec_d.offset = 1'b1;
                dec_d.mbyte  = 1'b1;
                dec_d.down   = 1'b1;
            end
            OPC_SB: begin
                dec_d.offset = 1'b1;
                dec_d.memw   = 2'b01;
                dec_d.wb     = 1'b0;
            end
            OPC_LW: begin
                dec_d.offset = 1'b1;
                dec_d.down   = 1'b1;
            end
            OPC_SW: begin
                dec_d.offset = 1'b1;
                dec_d.memw   = 2'b10;
                dec_d.wb     = 1'b0;
            end
            OPC_BGT: begin
                dec_d.bra = 2'b10;
                dec_d.wb  = 1'b0;
            end
            OPC_BLT: begin
                dec_d.bra = 2'b01;
                dec_d.wb  = 1'b0;
            end
            OPC_BEQ: begin
                dec_d.bra = 2'b00;
                dec_d.wb  = 1'b0;
            end
            OPC_HALT: begin
                dec_d.wb  = 1'b0;
                is_halt_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Flush and stall are combinational so IF/ID reacts in the same cycle.
    always_comb begin
        take_flush = ex_q.valid & (ex_q.bra != 2'b11) & bus.br_taken;
        stall      = (state_q == S_MULDIV) | (state_q == S_HALT) |
                     ((state_q == S_RUN) & bus.ld_use & ~take_flush);
    end

    // Sequencer FSM and ID/EX control-word register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            ex_q    <= BUBBLE;
        end else begin
            case (state_q)
                S_RUN: begin
                    // A taken branch kills the ID shadow, including HALT/MUL there.
                    if (take_flush || bus.ld_use || !bus.in_valid) begin
                        ex_q <= BUBBLE;
                    end else begin
                        ex_q <= dec_d;
                        if (is_halt_d) begin
                            state_q <= S_HALT;
                        end else if (is_muldiv_d && (MULDIV_LAT > 1)) begin
                            state_q <= S_MULDIV;
                            cnt_q   <= CNT_W'(MULDIV_LAT - 1);
                        end
                    end
                end
                S_MULDIV: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= S_RUN;
                    end
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_HALT: begin
                    ex_q <= BUBBLE;
                end
                default: begin
                    state_q <= S_RUN;
                    cnt_q   <= '0;
                    ex_q    <= BUBBLE;
                end
            endcase
        end
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_offset   = ex_q.offset;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_down     = ex_q.down;
    assign bus.ex_mbyte    = ex_q.mbyte;
    assign bus.ex_mv1src   = ex_q.mv1src;
    assign bus.ex_fdst     = ex_q.fdst;
    assign bus.ex_bra      = ex_q.bra;
    assign bus.ex_wdst     = ex_q.wdst;
    assign bus.ex_memw     = ex_q.memw;
    assign bus.ex_wb       = ex_q.wb;
    assign bus.stall       = stall;
    assign bus.if_flush_n  = ~take_flush;
    assign bus.id_flush_n  = ~take_flush;
    assign bus.muldiv_busy = (state_q == S_MULDIV);
    assign bus.halted      = (state_q == S_HALT);
endmodule
